// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes for one frame, snooped off the LBP write port,
// then streamed out bin by bin over valid/ready once the LBP stage signals finish.
module lbp_hist #(
  parameter int CNT_W = 14,
  parameter int BIN_N = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] pix_total,
  output logic             hist_done
);
  typedef enum logic [1:0] {ACCUM = 2'd0, DUMP = 2'd1, DONE = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bin_q [BIN_N];
  logic [CNT_W-1:0] pix_q;
  logic [7:0]       idx_q;
  logic             armed_q;
  logic             addr_ok, cnt_en, clr, beat;

  assign addr_ok = ({1'b0, lbp_addr} <= 15'd16383);
  assign cnt_en  = (state_q == ACCUM) && lbp_valid && addr_ok;
  assign clr     = (state_q == DONE) && start;
  assign beat    = (state_q == DUMP) && hist_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // armed_q blocks a finish level left over from the previous frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (finish && armed_q) state_d = DUMP;
      DUMP:    if (hist_ready && idx_q == 8'd255) state_d = DONE;
      DONE:    if (start) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // single-cycle read-modify-write keeps back-to-back hits on one bin exact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < BIN_N; b++) bin_q[b] <= '0;
      pix_q <= '0;
    end else if (clr) begin
      for (int b = 0; b < BIN_N; b++) bin_q[b] <= '0;
      pix_q <= '0;
    end else if (cnt_en) begin
      if (bin_q[lbp_data] != CNT_MAX) bin_q[lbp_data] <= bin_q[lbp_data] + CNT_ONE;
      if (pix_q != CNT_MAX) pix_q <= pix_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      if (state_q == ACCUM)              idx_q <= '0;
      else if (beat && idx_q != 8'd255)  idx_q <= idx_q + 8'd1;
      if (clr)          armed_q <= 1'b0;
      else if (!finish) armed_q <= 1'b1;
    end
  end

  // bins are frozen outside ACCUM, so the count is read straight off them
  always_comb begin
    hist_valid = (state_q == DUMP);
    hist_done  = (state_q == DONE);
    hist_bin   = idx_q;
    hist_count = hist_valid ? bin_q[idx_q] : '0;
  end

  assign pix_total = pix_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: vector table for accumulation, hand sequences for dump/start/reset.
module tb_lbp_hist;
  logic        clk = 1'b0;
  logic        reset, start, lbp_valid, finish, hist_ready;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        hist_valid, hist_done;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count, pix_total;

  int checks = 0, failures = 0;
  int got [256];
  int exp_bins [256];
  int dump_cyc;

  typedef struct { logic [7:0] code; int n; bit gap; int exp_total; } vec_t;
  vec_t tv [4];

  lbp_hist dut (
    .clk(clk), .reset(reset), .start(start), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count), .pix_total(pix_total), .hist_done(hist_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
    lbp_addr = '0; lbp_data = '0;
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] code, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      lbp_valid = 1'b1; lbp_data = code; lbp_addr = 14'(i);
      @(posedge clk); #1;
      if (exp_bins[code] < 16383) exp_bins[code]++;
      if (gap) begin
        lbp_valid = 1'b0; lbp_data = ~code;
        @(posedge clk); #1;
      end
    end
    lbp_valid = 1'b0;
  endtask

  task automatic enter_dump(input string nm);
    finish = 1'b1;
    @(posedge clk); #1;
    chk(nm, hist_valid, 1);
  endtask

  task automatic dump(input bit toggle);
    int idx = 0;
    int cyc = 0;
    int bad_seq = 0;
    int bad_hold = 0;
    logic [13:0] pc = '0;
    bit held = 1'b0;
    while (idx < 256 && cyc < 3000) begin
      hist_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (!hist_valid || hist_bin != idx[7:0]) bad_seq++;
      if (held && hist_count != pc) bad_hold++;
      got[idx] = int'(hist_count);
      pc = hist_count;
      @(posedge clk); #1;
      cyc++;
      held = !hist_ready;
      if (hist_ready) idx++;
    end
    hist_ready = 1'b0;
    dump_cyc = cyc;
    chk("dump_beats", idx, 256);
    chk("dump_order", bad_seq, 0);
    chk("dump_hold", bad_hold, 0);
  endtask

  initial begin
    int others, sum, bad, n;
    tv[0] = '{8'h3C, 6, 1'b1, 6};
    tv[1] = '{8'h00, 3, 1'b0, 9};
    tv[2] = '{8'h3C, 4, 1'b0, 13};
    tv[3] = '{8'h00, 2, 1'b1, 15};

    // reset state, observed before any clock edge
    reset = 1'b0; start = 1'b0; lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
    lbp_addr = '0; lbp_data = '0;
    #1;
    chk("rst_valid", hist_valid, 0);
    chk("rst_done", hist_done, 0);
    chk("rst_bin", hist_bin, 0);
    chk("rst_count", hist_count, 0);
    chk("rst_total", pix_total, 0);

    // 1: table-driven accumulation, then full-speed dump
    do_reset();
    for (int v = 0; v < 4; v++) begin
      push(tv[v].code, tv[v].n, tv[v].gap);
      chk($sformatf("t1_total_%0d", v), pix_total, tv[v].exp_total);
    end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("t1_start_ignored", pix_total, 15);
    enter_dump("t1_enter");
    chk("t1_first_count", hist_count, 5);
    dump(1'b0);
    chk("t1_cycles", dump_cyc, 256);
    chk("t1_bin00", got[8'h00], 5);
    chk("t1_bin3C", got[8'h3C], 10);
    others = 0;
    for (int i = 0; i < 256; i++) if (i != 8'h00 && i != 8'h3C) others += got[i];
    chk("t1_others", others, 0);
    chk("t1_total", pix_total, 15);
    chk("t1_done", hist_done, 1);
    chk("t1_valid_off", hist_valid, 0);

    // 2: back-to-back valids, finish rises with the last; valids during dump ignored
    do_reset();
    lbp_valid = 1'b1; lbp_data = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    finish = 1'b1;
    @(posedge clk); #1;
    chk("t2_enter", hist_valid, 1);
    dump(1'b0);
    lbp_valid = 1'b0;
    chk("t2_binFF", got[8'hFF], 4);
    chk("t2_total", pix_total, 4);

    // 3: dump with ready pattern 1,0,0
    do_reset();
    push(8'h10, 2, 1'b0);
    push(8'hFE, 1, 1'b0);
    enter_dump("t3_enter");
    dump(1'b1);
    chk("t3_bin10", got[8'h10], 2);
    chk("t3_binFE", got[8'hFE], 1);
    chk("t3_done", hist_done, 1);

    // 4: full frame, then start with finish still high
    do_reset();
    for (int i = 0; i < 15876; i++) begin
      lbp_valid = 1'b1; lbp_data = 8'(i * 7); lbp_addr = 14'(i);
      @(posedge clk); #1;
      exp_bins[8'(i * 7)]++;
    end
    lbp_valid = 1'b0;
    enter_dump("t4_enter");
    dump(1'b0);
    sum = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin
      sum += got[i];
      if (got[i] != exp_bins[i]) bad++;
    end
    chk("t4_sum", sum, 15876);
    chk("t4_bins", bad, 0);
    chk("t4_total", pix_total, 15876);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("t4_clr_done", hist_done, 0);
    chk("t4_clr_total", pix_total, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("t4_wait_armed", hist_valid, 0);
    finish = 1'b0; @(posedge clk); #1;
    enter_dump("t4_reenter");
    dump(1'b0);
    sum = 0;
    for (int i = 0; i < 256; i++) sum += got[i];
    chk("t4_cleared_sum", sum, 0);

    // 5: saturation
    do_reset();
    push(8'h01, 16390, 1'b0);
    chk("t5_total_sat", pix_total, 16383);
    enter_dump("t5_enter");
    dump(1'b0);
    chk("t5_bin01_sat", got[8'h01], 16383);

    // 6: asynchronous reset mid-dump
    do_reset();
    push(8'h80, 3, 1'b0);
    enter_dump("t6_enter");
    n = 0;
    while (hist_bin != 8'h80 && n < 300) begin
      hist_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    hist_ready = 1'b0;
    chk("t6_at_80", hist_bin, 8'h80);
    chk("t6_count_80", hist_count, 3);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", hist_valid, 0);
    chk("t6_async_done", hist_done, 0);
    chk("t6_async_total", pix_total, 0);
    chk("t6_async_bin", hist_bin, 0);
    @(posedge clk); #1;
    finish = 1'b0; reset = 1'b1;
    push(8'h05, 1, 1'b0);
    chk("t6_accum_total", pix_total, 1);
    chk("t6_accum_valid", hist_valid, 0);
    enter_dump("t6_reenter");
    dump(1'b0);
    chk("t6_bin80_cleared", got[8'h80], 0);
    chk("t6_bin05", got[8'h05], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
